alu_seq: RTL

Operand sequencer and result register that sits directly upstream of `alu`. It collects `a`, `b` and `f` as three beats over one narrow valid/ready input channel, then drives the combinational `alu`. It captures `y`/`t` into registers and presents them on a valid/ready output channel. It replaces free-running random stimulus with a cycle-accurate, back-pressurable front end for board and bench use.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 43 ++++
 rtl/alu_seq.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu datapath and its operand sequencer:
// opcodes, compare-flag bit positions and the sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_SUB = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    localparam int T_EQ  = 0;
    localparam int T_SLT = 1;
    localparam int T_ULT = 2;

    typedef enum logic [2:0] {
        LD_A = 3'd0,
        LD_B = 3'd1,
        LD_F = 3'd2,
        EXEC = 3'd3,
        OUT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: eight operations selected by f, plus eq / signed-lt /
// unsigned-lt flags comparing a against b.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       t
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (f)
            ALU_SUB: y = a - b;
            ALU_ADD: y = a + b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SRL: y = a >> shamt;
            ALU_SLL: y = a << shamt;
            ALU_SRA: y = $unsigned($signed(a) >>> shamt);
            default: y = '0;
        endcase
    end

    always_comb begin
        t        = '0;
        t[T_EQ]  = (a == b);
        t[T_SLT] = ($signed(a) < $signed(b));
        t[T_ULT] = (a < b);
    end

endmodule

// File: rtl/alu_seq.sv
// Operand sequencer in front of alu: gathers a, b, f as three input beats,
// runs one EXEC cycle, then holds the registered result until it is taken.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_y,
    output logic [2:0]       res_t,
    output logic [2:0]       res_f,
    output logic [15:0]      op_cnt,
    output logic [2:0]       dbg_state
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SH_MASK = {{(WIDTH-SHW){1'b0}}, {SHW{1'b1}}};

    seq_state_t       state, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       f_q;
    logic [WIDTH-1:0] alu_y;
    logic [2:0]       alu_t;
    logic             in_fire, out_fire;

    // Both channels: a transfer happens on a rising edge where valid && ready.
    // ready/valid driven here depend on state only, never on the partner's signal.
    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            LD_A, LD_B, LD_F: in_ready = 1'b1;
            OUT:              out_valid = 1'b1;
            default:          ;
        endcase
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        case (state)
            LD_A:    if (in_fire)  state_d = LD_B;
            LD_B:    if (in_fire)  state_d = LD_F;
            LD_F:    if (in_fire)  state_d = EXEC;
            EXEC:                  state_d = OUT;
            OUT:     if (out_fire) state_d = LD_A;
            default:               state_d = LD_A;
        endcase
        if (clr) state_d = LD_A;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= LD_A;
            a_q    <= '0;
            b_q    <= '0;
            f_q    <= '0;
            res_y  <= '0;
            res_t  <= '0;
            res_f  <= '0;
            op_cnt <= '0;
        end else begin
            state <= state_d;
            if (!clr) begin
                if (in_fire && state == LD_A) a_q <= in_data;
                if (in_fire && state == LD_B) b_q <= in_data;
                if (in_fire && state == LD_F) begin
                    f_q <= in_data[2:0];
                    // Shift ops only look at the low shift-amount bits of b.
                    if (in_data[2:0] >= ALU_SRL) b_q <= b_q & SH_MASK;
                end
                if (state == EXEC) begin
                    res_y <= alu_y;
                    res_t <= alu_t;
                    res_f <= f_q;
                end
                if (out_fire) op_cnt <= op_cnt + 16'd1;
            end
        end
    end

    assign dbg_state = state;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a (a_q),
        .b (b_q),
        .f (f_q),
        .y (alu_y),
        .t (alu_t)
    );

endmodule
